tdm_rx: RTL and testbench

- Multichannel serial-audio receiver. Supports I2S (2 ch) and TDM (up to 16 ch) frames, with configurable slot width, data delay and frame-sync polarity.
- Runs entirely in the system clock domain. sck, ws and sd are oversampled through synchronisers; no logic is clocked by sck.
- Delivers one complete, framed PCM word set per audio frame, with a valid strobe and a framing-error strobe, to downstream DSP/FIFO blocks.

---
 rtl/tdm_rx.sv | 142 ++++++++++++++
 tb/tb_tdm_rx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/tdm_rx.sv
// Oversampled I2S/TDM serial-audio receiver running entirely on clk.
// Delivers one parallel word set per frame with dv, ferr and lock.
module tdm_rx #(
  parameter int b    = 16,
  parameter int n    = 2,
  parameter int sw   = 32,
  parameter int dly  = 1,
  parameter int fpol = 0,
  parameter int sync = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sck,
  input  logic           ws,
  input  logic           sd,
  output logic [n*b-1:0] d,
  output logic           dv,
  output logic           ferr,
  output logic           lock
);

  localparam int flen = n * sw;

  typedef enum logic {HUNT, RUN} state_t;

  state_t         state, state_nx;
  logic [sync-1:0] sck_q, ws_q, sd_q;
  logic           sck_prev, ws_prev;
  logic           rise, fsync, ws_s, sd_s;
  logic [9:0]     bc, bc_nx;
  logic [n*b-1:0] shadow, shadow_nx, sh_close;
  logic           dv_nx, ferr_nx, load;

  // Writes one serial bit at payload position pos; bit 0 of a slot clears it.
  function automatic logic [n*b-1:0] cap(input logic [n*b-1:0] sh,
                                         input int pos, input logic bitv);
    logic [n*b-1:0] r;
    r = sh;
    for (int s = 0; s < n; s++) begin
      if (pos == s * sw) r[s*b +: b] = '0;
      for (int t = 0; t < b; t++)
        if (t < sw && pos == s * sw + t) r[s*b + b - 1 - t] = bitv;
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_q    <= '0;
      ws_q     <= '0;
      sd_q     <= '0;
      sck_prev <= 1'b0;
      ws_prev  <= 1'b0;
    end else begin
      sck_q    <= {sck_q[sync-2:0], sck};
      ws_q     <= {ws_q[sync-2:0], ws};
      sd_q     <= {sd_q[sync-2:0], sd};
      sck_prev <= sck_q[sync-1];
      if (rise) ws_prev <= ws_s;
    end
  end

  assign ws_s  = ws_q[sync-1];
  assign sd_s  = sd_q[sync-1];
  assign rise  = sck_q[sync-1] & ~sck_prev;
  assign fsync = rise & ((fpol != 0) ? (ws_s & ~ws_prev) : (~ws_s & ws_prev));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HUNT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      HUNT: if (fsync) state_nx = RUN;
      RUN:  if (rise && !fsync && bc == 10'd1022) state_nx = HUNT;
      default: state_nx = HUNT;
    endcase
  end

  // The closing rise may still carry the last payload bit (dly=1), so the
  // old frame is completed into sh_close before the copy and the restart.
  always_comb begin
    dv_nx     = 1'b0;
    ferr_nx   = 1'b0;
    load      = 1'b0;
    bc_nx     = bc;
    sh_close  = cap(shadow, int'(bc) + 1 - dly, sd_s);
    shadow_nx = shadow;
    if (rise) begin
      case (state)
        HUNT: begin
          if (fsync) begin
            bc_nx     = '0;
            shadow_nx = cap(shadow, -dly, sd_s);
          end
        end
        RUN: begin
          if (fsync) begin
            if (int'(bc) + 1 == flen) begin
              load  = 1'b1;
              dv_nx = 1'b1;
            end else begin
              ferr_nx = 1'b1;
            end
            bc_nx     = '0;
            shadow_nx = cap(sh_close, -dly, sd_s);
          end else if (bc == 10'd1022) begin
            ferr_nx   = 1'b1;
            bc_nx     = '0;
            shadow_nx = sh_close;
          end else begin
            bc_nx     = bc + 10'd1;
            shadow_nx = sh_close;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bc     <= '0;
      shadow <= '0;
      d      <= '0;
      dv     <= 1'b0;
      ferr   <= 1'b0;
      lock   <= 1'b0;
    end else begin
      bc     <= bc_nx;
      shadow <= shadow_nx;
      dv     <= dv_nx;
      ferr   <= ferr_nx;
      if (load) d <= sh_close;
      if (dv_nx)        lock <= 1'b1;
      else if (ferr_nx) lock <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tdm_rx.sv
// Directed bench for tdm_rx: I2S default instance plus a 4-slot TDM instance
// sharing one serial source; frames are built bit by bit from word tables.
module tb_tdm_rx;
  logic        clk = 1'b0;
  logic        rst, sck, ws, sd;
  logic [31:0] d_a;
  logic        dv_a, ferr_a, lock_a;
  logic [95:0] d_b;
  logic        dv_b, ferr_b, lock_b;

  int n_vec = 0, n_err = 0;
  int half = 40;
  int ndv_a = 0, nferr_a = 0, ndv_b = 0, nferr_b = 0;
  logic [31:0] dq_a [0:15];
  logic [95:0] dq_b [0:15];
  logic [31:0] fw [0:3];

  always #5 clk = ~clk;

  tdm_rx u_a (
    .clk(clk), .rst(rst), .sck(sck), .ws(ws), .sd(sd),
    .d(d_a), .dv(dv_a), .ferr(ferr_a), .lock(lock_a)
  );

  tdm_rx #(.b(24), .n(4), .sw(16), .dly(0), .fpol(1), .sync(2)) u_b (
    .clk(clk), .rst(rst), .sck(sck), .ws(ws), .sd(sd),
    .d(d_b), .dv(dv_b), .ferr(ferr_b), .lock(lock_b)
  );

  always @(negedge clk) begin
    if (dv_a) begin
      if (ndv_a < 16) dq_a[ndv_a] = d_a;
      ndv_a++;
    end
    if (ferr_a) nferr_a++;
    if (dv_b) begin
      if (ndv_b < 16) dq_b[ndv_b] = d_b;
      ndv_b++;
    end
    if (ferr_b) nferr_b++;
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic wsv, input logic sdv);
    sck = 1'b0; ws = wsv; sd = sdv;
    #(half);
    sck = 1'b1;
    #(half);
  endtask

  task automatic idle(input int cnt, input logic wsv);
    for (int i = 0; i < cnt; i++) tick(wsv, 1'b0);
  endtask

  task automatic words(input logic [31:0] w0, w1, w2, w3);
    fw[0] = w0; fw[1] = w1; fw[2] = w2; fw[3] = w3;
  endtask

  // Rises first..last-1 of one frame; words are left-justified in 32 bits.
  task automatic send(input int nch, input int swd, input int dl, input int fp,
                      input int first, input int last);
    logic [31:0] w;
    int p;
    logic wsv, sdv;
    for (int i = first; i < last; i++) begin
      p   = i - dl;
      wsv = (fp == 0) ? (i >= swd) : (i == 0);
      sdv = 1'b0;
      if (p >= 0 && p < nch * swd) begin
        w   = fw[p / swd];
        sdv = w[31 - (p % swd)];
      end
      tick(wsv, sdv);
    end
  endtask

  task automatic i2s(input logic [31:0] l, input logic [31:0] r, input int len);
    words(l, r, 32'h0, 32'h0);
    send(2, 32, 1, 0, 0, len);
  endtask

  initial begin
    rst = 1'b1; sck = 1'b0; ws = 1'b1; sd = 1'b0;
    #22;
    check("rst_d_a",    {64'h0, d_a}, 96'h0);
    check("rst_dv_a",   {95'h0, dv_a}, 96'h0);
    check("rst_ferr_a", {95'h0, ferr_a}, 96'h0);
    check("rst_lock_a", {95'h0, lock_a}, 96'h0);
    check("rst_d_b",    d_b, 96'h0);
    rst = 1'b0;
    #20;

    // partial right half, then a full frame: nothing delivered yet
    idle(20, 1'b1);
    i2s(32'hA5C3_0000, 32'h1234_0000, 64);
    check("hunt_no_dv", ndv_a, 0);
    check("hunt_lock",  {95'h0, lock_a}, 96'h0);

    // 24-bit sender word truncated to 16 bits
    i2s(32'hABCD_EF00, 32'h8000_0000, 64);
    check("i2s_dv_cnt", ndv_a, 1);
    check("i2s_d1",     {64'h0, dq_a[0]}, {64'h0, 32'h1234_A5C3});
    check("i2s_lock",   {95'h0, lock_a}, 96'h1);
    check("i2s_noferr", nferr_a, 0);

    // short frame after lock
    i2s(32'h1111_0000, 32'h2222_0000, 63);
    check("trunc_dv_cnt", ndv_a, 2);
    check("trunc_d2",     {64'h0, dq_a[1]}, {64'h0, 32'h8000_ABCD});
    i2s(32'h5A5A_0000, 32'hC3C3_0000, 64);
    check("short_ferr",   nferr_a, 1);
    check("short_lock",   {95'h0, lock_a}, 96'h0);
    check("short_keep_d", {64'h0, d_a}, {64'h0, 32'h8000_ABCD});
    check("short_no_dv",  ndv_a, 2);
    i2s(32'h0F0F_0000, 32'hF0F0_0000, 64);
    check("relock_dv_cnt", ndv_a, 3);
    check("relock_d3",     {64'h0, dq_a[2]}, {64'h0, 32'hC3C3_5A5A});
    check("relock_lock",   {95'h0, lock_a}, 96'h1);

    // no frame sync for 1100 rises
    idle(1100, 1'b1);
    check("tmo_ferr",  nferr_a, 2);
    check("tmo_lock",  {95'h0, lock_a}, 96'h0);
    check("tmo_no_dv", ndv_a, 3);
    i2s(32'h1111_0000, 32'h2222_0000, 64);
    check("tmo_first_no_dv", ndv_a, 3);
    i2s(32'h3333_0000, 32'h4444_0000, 64);
    check("tmo_second_dv", ndv_a, 4);
    check("tmo_d4",        {64'h0, dq_a[3]}, {64'h0, 32'h2222_1111});

    // clk:sck ratio of exactly 4
    half = 20;
    i2s(32'hDEAD_0000, 32'hBEEF_0000, 64);
    i2s(32'h0001_0000, 32'h8000_0000, 64);
    check("r4_dv_cnt", ndv_a, 6);
    check("r4_d5",     {64'h0, dq_a[4]}, {64'h0, 32'h4444_3333});
    check("r4_d6",     {64'h0, dq_a[5]}, {64'h0, 32'hBEEF_DEAD});
    check("r4_nferr",  nferr_a, 2);
    half = 40;

    // asynchronous reset in the middle of slot 0
    words(32'h7777_0000, 32'h6666_0000, 32'h0, 32'h0);
    send(2, 32, 1, 0, 0, 10);
    check("pre_rst_dv",   ndv_a, 7);
    check("pre_rst_d7",   {64'h0, dq_a[6]}, {64'h0, 32'h8000_0001});
    check("pre_rst_lock", {95'h0, lock_a}, 96'h1);
    #17 rst = 1'b1;
    #1;
    check("arst_d",    {64'h0, d_a}, 96'h0);
    check("arst_dv",   {95'h0, dv_a}, 96'h0);
    check("arst_ferr", {95'h0, ferr_a}, 96'h0);
    check("arst_lock", {95'h0, lock_a}, 96'h0);
    #20 rst = 1'b0;
    send(2, 32, 1, 0, 10, 64);
    i2s(32'h1357_0000, 32'h2468_0000, 64);
    check("post_rst_no_dv", ndv_a, 7);
    i2s(32'hAAAA_0000, 32'hBBBB_0000, 64);
    check("post_rst_dv",   ndv_a, 8);
    check("post_rst_d8",   {64'h0, dq_a[7]}, {64'h0, 32'h2468_1357});
    check("post_rst_ferr", nferr_a, 2);

    // 4-slot TDM, 24-bit output, 16-sck slots, no delay, rising sync
    rst = 1'b1;
    #10 rst = 1'b0;
    ndv_b = 0; nferr_b = 0;
    idle(5, 1'b0);
    words(32'h8001_0000, 32'h7FFF_0000, 32'h0000_0000, 32'hFFFF_0000);
    send(4, 16, 0, 1, 0, 64);
    check("tdm_hunt_no_dv", ndv_b, 0);
    words(32'h1234_0000, 32'h5678_0000, 32'h9ABC_0000, 32'hDEF0_0000);
    send(4, 16, 0, 1, 0, 64);
    words(32'h0, 32'h0, 32'h0, 32'h0);
    send(4, 16, 0, 1, 0, 64);
    check("tdm_dv_cnt", ndv_b, 2);
    check("tdm_d1",     dq_b[0], 96'hFFFF00_000000_7FFF00_800100);
    check("tdm_d2",     dq_b[1], 96'hDEF000_9ABC00_567800_123400);
    check("tdm_lock",   {95'h0, lock_b}, 96'h1);
    check("tdm_nferr",  nferr_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
